// File: rtl/regfile_bypass.sv
// General-purpose register file for the ID stage with EX/MEM/WB operand
// forwarding, load-use hazard detection and a saturating stall-cycle counter.
module regfile_bypass #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD*DATA_W-1:0] rdata,
    output logic                    stall_req,
    input  logic                    ex_we,
    input  logic [ADDR_W-1:0]       ex_waddr,
    input  logic [DATA_W-1:0]       ex_wdata,
    input  logic                    ex_data_ok,
    input  logic                    mem_we,
    input  logic [ADDR_W-1:0]       mem_waddr,
    input  logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_data_ok,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [CNT_W-1:0]        r_cnt;
    logic [NREAD*DATA_W-1:0] w_rdata;
    logic [NREAD-1:0]        w_hazard;
    logic                    w_stall;

    // Entry 0 is cleared on reset and never written, so it always holds zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Youngest matching stage wins; an unproduced EX/MEM value flags a hazard.
    always_comb begin
        w_rdata  = '0;
        w_hazard = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            if (raddr[i*ADDR_W +: ADDR_W] == '0) begin
                w_rdata[i*DATA_W +: DATA_W] = '0;
            end else if (ex_we && (ex_waddr == raddr[i*ADDR_W +: ADDR_W])) begin
                w_rdata[i*DATA_W +: DATA_W] = ex_wdata;
                w_hazard[i]                 = !ex_data_ok;
            end else if (mem_we && (mem_waddr == raddr[i*ADDR_W +: ADDR_W])) begin
                w_rdata[i*DATA_W +: DATA_W] = mem_wdata;
                w_hazard[i]                 = !mem_data_ok;
            end else if (we && (waddr == raddr[i*ADDR_W +: ADDR_W])) begin
                w_rdata[i*DATA_W +: DATA_W] = wdata;
            end else begin
                w_rdata[i*DATA_W +: DATA_W] = r_mem[raddr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign w_stall = |w_hazard;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign rdata     = w_rdata;
    assign stall_req = w_stall;
    assign stall_cnt = r_cnt;

endmodule
